// File: rtl/seg_pair_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pair_monitor
//  Description : Receive-side checker for a two-digit active-low 7-segment
//                bus. Decodes the ones/tens bytes back to a binary count,
//                tracks the count sequence, locks on a run of good steps
//                and flags illegal codes and broken sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_pair_monitor #(
  parameter int MAX_VAL    = 15,  // highest legal count, wraps to 0
  parameter int LOCK_N     = 4,   // good transitions needed to lock (1..15)
  parameter int ALLOW_HOLD = 1    // 1: repeated value is a good transition
) (
  input  logic       ck,
  input  logic       rs,
  input  logic [7:0] seg_ones,
  input  logic [7:0] seg_tens,
  output logic [4:0] value,
  output logic       value_ok,
  output logic       locked,
  output logic       code_bad,
  output logic       seq_err,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [6:0] c_max_wide = 7'(MAX_VAL);
  localparam logic [4:0] c_max_val  = 5'(MAX_VAL);
  localparam logic [3:0] c_lock_n   = 4'(LOCK_N);
  localparam logic       c_hold_ok  = (ALLOW_HOLD != 0);

  // Returns {legal, digit}; the full byte must match, so a lit dp is illegal.
  function automatic logic [4:0] f_seg_decode(input logic [7:0] code);
    logic [4:0] res;
    case (code)
      8'hC0:   res = {1'b1, 4'd0};
      8'hF9:   res = {1'b1, 4'd1};
      8'hA4:   res = {1'b1, 4'd2};
      8'hB0:   res = {1'b1, 4'd3};
      8'h99:   res = {1'b1, 4'd4};
      8'h92:   res = {1'b1, 4'd5};
      8'h82:   res = {1'b1, 4'd6};
      8'hF8:   res = {1'b1, 4'd7};
      8'h80:   res = {1'b1, 4'd8};
      8'h90:   res = {1'b1, 4'd9};
      default: res = {1'b0, 4'd0};
    endcase
    return res;
  endfunction

  // Stage-1 sample registers
  logic [7:0] r_s1_ones;
  logic [7:0] r_s1_tens;

  // Output / FSM registers
  state_t     r_state;
  logic [3:0] r_good_cnt;
  logic [4:0] r_value;
  logic       r_value_ok;
  logic       r_locked;
  logic       r_code_bad;
  logic       r_seq_err;
  logic [7:0] r_err_cnt;

  // Decode and next-state wires
  logic [4:0] w_ones_dec;
  logic [4:0] w_tens_dec;
  logic [6:0] w_dec_wide;
  logic [4:0] w_dec;
  logic       w_legal;
  logic [4:0] w_expect_nxt;
  logic       w_good;
  logic [3:0] w_cnt_inc;

  state_t     w_state_nxt;
  logic [3:0] w_good_cnt_nxt;
  logic [4:0] w_value_nxt;
  logic       w_value_ok_nxt;
  logic       w_code_bad_nxt;
  logic       w_seq_err_nxt;
  logic [7:0] w_err_cnt_nxt;

  // Capture the raw bus; reset loads an illegal code so the first decode flags.
  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      r_s1_ones <= 8'hFF;
      r_s1_tens <= 8'hFF;
    end else begin
      r_s1_ones <= seg_ones;
      r_s1_tens <= seg_tens;
    end
  end

  // Decode is kept 7 bits wide so that 16..99 are caught as out of range
  // rather than aliasing into the 5-bit value.
  assign w_ones_dec   = f_seg_decode(r_s1_ones);
  assign w_tens_dec   = f_seg_decode(r_s1_tens);
  assign w_dec_wide   = {3'd0, w_tens_dec[3:0]} * 7'd10 + {3'd0, w_ones_dec[3:0]};
  assign w_dec        = w_dec_wide[4:0];
  assign w_legal      = w_ones_dec[4] & w_tens_dec[4] & (w_dec_wide <= c_max_wide);
  assign w_expect_nxt = (r_value == c_max_val) ? 5'd0 : r_value + 5'd1;
  assign w_good       = (w_dec == w_expect_nxt) ||
                        (c_hold_ok && (w_dec == r_value)) ||
                        (w_dec == 5'd0);
  assign w_cnt_inc    = r_good_cnt + 4'd1;

  // Next-state and registered-output logic for the HUNT/ACQ/LOCKED tracker.
  always_comb begin
    w_state_nxt    = r_state;
    w_good_cnt_nxt = r_good_cnt;
    w_value_nxt    = r_value;
    w_value_ok_nxt = w_legal;
    w_code_bad_nxt = ~w_legal;
    w_seq_err_nxt  = 1'b0;
    w_err_cnt_nxt  = r_err_cnt;

    // value always follows the last legal decode; illegal decodes hold it
    if (w_legal) begin
      w_value_nxt = w_dec;
    end

    case (r_state)
      ST_HUNT: begin
        if (w_legal) begin
          w_good_cnt_nxt = 4'd0;
          w_state_nxt    = ST_ACQ;
        end
      end
      ST_ACQ: begin
        if (!w_legal) begin
          w_state_nxt = ST_HUNT;
        end else if (w_good) begin
          w_good_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == c_lock_n) begin
            w_state_nxt = ST_LOCKED;
          end
        end else begin
          w_good_cnt_nxt = 4'd0;
        end
      end
      ST_LOCKED: begin
        if (!w_legal || !w_good) begin
          w_seq_err_nxt = 1'b1;
          if (r_err_cnt != 8'hFF) begin
            w_err_cnt_nxt = r_err_cnt + 8'd1;
          end
          w_state_nxt = ST_HUNT;
        end
      end
      default: begin
        w_state_nxt = ST_HUNT;
      end
    endcase
  end

  // State and output registers, updated from the stage-1 decode.
  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      r_state    <= ST_HUNT;
      r_good_cnt <= 4'd0;
      r_value    <= 5'd0;
      r_value_ok <= 1'b0;
      r_locked   <= 1'b0;
      r_code_bad <= 1'b0;
      r_seq_err  <= 1'b0;
      r_err_cnt  <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_cnt_nxt;
      r_value    <= w_value_nxt;
      r_value_ok <= w_value_ok_nxt;
      r_locked   <= (w_state_nxt == ST_LOCKED);
      r_code_bad <= w_code_bad_nxt;
      r_seq_err  <= w_seq_err_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
    end
  end

  assign value    = r_value;
  assign value_ok = r_value_ok;
  assign locked   = r_locked;
  assign code_bad = r_code_bad;
  assign seq_err  = r_seq_err;
  assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seg_pair_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_pair_monitor
//  Description : Scoreboard bench for seg_pair_monitor. Two instances share
//                one bus: default parameters, and MAX_VAL=12 / LOCK_N=3 /
//                ALLOW_HOLD=0. A behavioural model predicts each response.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg_pair_monitor;

  logic       ck = 1'b0;
  logic       rs = 1'b0;
  logic [7:0] seg_ones = 8'hFF;
  logic [7:0] seg_tens = 8'hFF;

  logic [4:0] a_value, b_value;
  logic       a_value_ok, b_value_ok;
  logic       a_locked, b_locked;
  logic       a_code_bad, b_code_bad;
  logic       a_seq_err, b_seq_err;
  logic [7:0] a_err_cnt, b_err_cnt;

  seg_pair_monitor #(.MAX_VAL(15), .LOCK_N(4), .ALLOW_HOLD(1)) u_dut_a (
    .ck(ck), .rs(rs), .seg_ones(seg_ones), .seg_tens(seg_tens),
    .value(a_value), .value_ok(a_value_ok), .locked(a_locked),
    .code_bad(a_code_bad), .seq_err(a_seq_err), .err_cnt(a_err_cnt)
  );

  seg_pair_monitor #(.MAX_VAL(12), .LOCK_N(3), .ALLOW_HOLD(0)) u_dut_b (
    .ck(ck), .rs(rs), .seg_ones(seg_ones), .seg_tens(seg_tens),
    .value(b_value), .value_ok(b_value_ok), .locked(b_locked),
    .code_bad(b_code_bad), .seq_err(b_seq_err), .err_cnt(b_err_cnt)
  );

  always #5 ck = ~ck;

  // Count of rising edges; expectations are tagged with the edge count at
  // which they become visible.
  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  typedef struct {
    int due;
    int value;
    int vok;
    int lk;
    int cb;
    int se;
    int err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_chk = 0;
  int n_err = 0;

  // Reference model state, one slot per instance
  int m_v[2];
  int m_mode[2];   // 0 hunting, 1 acquiring, 2 locked
  int m_run[2];
  int m_err[2];

  function automatic int p_mv(int i);  return (i == 0) ? 15 : 12; endfunction
  function automatic int p_ln(int i);  return (i == 0) ? 4  : 3;  endfunction
  function automatic int p_ah(int i);  return (i == 0) ? 1  : 0;  endfunction

  function automatic logic [7:0] seg_code(int d);
    case (d)
      0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0;
      4: return 8'h99; 5: return 8'h92; 6: return 8'h82; 7: return 8'hF8;
      8: return 8'h80; 9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic int seg_digit(logic [7:0] c);
    for (int k = 0; k < 10; k++) begin
      if (seg_code(k) == c) return k;
    end
    return -1;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 0; m_mode[i] = 0; m_run[i] = 0; m_err[i] = 0;
    end
  endtask

  // Apply the tracking rules to one byte pair and queue the response.
  task automatic model_step(int i, logic [7:0] o, logic [7:0] t, int due);
    int   od, td, d, nx;
    bit   legal, good;
    exp_t e;
    od = seg_digit(o);
    td = seg_digit(t);
    d  = td * 10 + od;
    legal = (od >= 0) && (td >= 0) && (d <= p_mv(i));
    nx = (m_v[i] == p_mv(i)) ? 0 : m_v[i] + 1;
    good = (d == nx) || ((p_ah(i) == 1) && (d == m_v[i])) || (d == 0);
    e.se = 0;
    if (m_mode[i] == 0) begin
      if (legal) begin m_mode[i] = 1; m_run[i] = 0; end
    end else if (m_mode[i] == 1) begin
      if (!legal) m_mode[i] = 0;
      else if (good) begin
        m_run[i]++;
        if (m_run[i] == p_ln(i)) m_mode[i] = 2;
      end else m_run[i] = 0;
    end else begin
      if (!legal || !good) begin
        e.se = 1;
        if (m_err[i] < 255) m_err[i]++;
        m_mode[i] = 0;
      end
    end
    if (legal) m_v[i] = d;
    e.due   = due;
    e.value = m_v[i];
    e.vok   = legal ? 1 : 0;
    e.lk    = (m_mode[i] == 2) ? 1 : 0;
    e.cb    = legal ? 0 : 1;
    e.err   = m_err[i];
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic cmp(string p, exp_t e, int v, int vok, int lk, int cb, int se, int err);
    chk({p, ".value"},    v,   e.value);
    chk({p, ".value_ok"}, vok, e.vok);
    chk({p, ".locked"},   lk,  e.lk);
    chk({p, ".code_bad"}, cb,  e.cb);
    chk({p, ".seq_err"},  se,  e.se);
    chk({p, ".err_cnt"},  err, e.err);
  endtask

  // Monitor: pop and compare every expectation that falls due this cycle.
  always @(negedge ck) begin
    exp_t e;
    if (rs) begin
      while (q0.size() > 0 && q0[0].due <= cyc) begin
        e = q0.pop_front();
        if (e.due < cyc) chk("a.stale", e.due, cyc);
        else cmp("a", e, int'(a_value), int'(a_value_ok), int'(a_locked),
                 int'(a_code_bad), int'(a_seq_err), int'(a_err_cnt));
      end
      while (q1.size() > 0 && q1[0].due <= cyc) begin
        e = q1.pop_front();
        if (e.due < cyc) chk("b.stale", e.due, cyc);
        else cmp("b", e, int'(b_value), int'(b_value_ok), int'(b_locked),
                 int'(b_code_bad), int'(b_seq_err), int'(b_err_cnt));
      end
    end
  end

  task automatic put_raw(logic [7:0] o, logic [7:0] t);
    seg_ones = o;
    seg_tens = t;
    model_step(0, o, t, cyc + 2);
    model_step(1, o, t, cyc + 2);
  endtask

  task automatic put(int v);
    put_raw(seg_code(v % 10), seg_code(v / 10));
  endtask

  task automatic step(int v);
    @(negedge ck); #1;
    put(v);
  endtask

  task automatic step_raw(logic [7:0] o, logic [7:0] t);
    @(negedge ck); #1;
    put_raw(o, t);
  endtask

  task automatic check_reset_state();
    chk("rst.a.value", int'(a_value), 0);      chk("rst.b.value", int'(b_value), 0);
    chk("rst.a.value_ok", int'(a_value_ok), 0); chk("rst.b.value_ok", int'(b_value_ok), 0);
    chk("rst.a.locked", int'(a_locked), 0);    chk("rst.b.locked", int'(b_locked), 0);
    chk("rst.a.code_bad", int'(a_code_bad), 0); chk("rst.b.code_bad", int'(b_code_bad), 0);
    chk("rst.a.seq_err", int'(a_seq_err), 0);  chk("rst.b.seq_err", int'(b_seq_err), 0);
    chk("rst.a.err_cnt", int'(a_err_cnt), 0);  chk("rst.b.err_cnt", int'(b_err_cnt), 0);
  endtask

  // Stage 1 still holds FF after release, so the first edge decodes FF/FF.
  task automatic release_rst(int v);
    @(negedge ck); #1;
    rs = 1'b1;
    model_reset();
    model_step(0, 8'hFF, 8'hFF, cyc + 1);
    model_step(1, 8'hFF, 8'hFF, cyc + 1);
    put(v);
  endtask

  task automatic assert_rst();
    @(negedge ck); #1;
    rs = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    check_reset_state();
    repeat (2) @(negedge ck);
  endtask

  initial begin
    int cv, r, k;
    logic [7:0] bad;

    repeat (3) @(negedge ck);
    #1;
    check_reset_state();

    // Clean count 0..15 twice, covering lock-up and the 15 -> 0 wrap
    release_rst(0);
    for (int s = 1; s < 34; s++) step(s % 16);
    cv = 33 % 16;

    // Randomised run: steps, holds, skips, counter resets, bad codes
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      begin cv = (cv + 1) % 16; step(cv); end
      else if (r < 76) step(cv);
      else if (r < 82) begin cv = (cv + 2) % 16; step(cv); end
      else if (r < 86) begin cv = 0; step(cv); end
      else if (r < 90) begin cv = int'($urandom_range(0, 15)); step(cv); end
      else if (r < 97) begin
        k = int'($urandom_range(0, 2));
        if (k == 0)      bad = 8'hFF;
        else if (k == 1) bad = seg_code(int'($urandom_range(0, 9))) & 8'h7F;
        else             bad = 8'($urandom);
        if (r < 94) step_raw(bad, seg_code(cv / 10));
        else        step_raw(seg_code(cv % 10), bad);
      end else step(int'($urandom_range(16, 99)));
    end

    // Mid-operation reset wipes the error history immediately
    assert_rst();
    release_rst(0);

    // Repeated lock-then-skip cycles drive err_cnt into saturation
    cv = 0;
    for (int n = 0; n < 300; n++) begin
      for (int j = 0; j < 7; j++) begin cv = (cv + 1) % 16; step(cv); end
      cv = (cv + 2) % 16;
      step(cv);
    end
    for (int s = 0; s < 12; s++) begin cv = (cv + 1) % 16; step(cv); end

    // Let outstanding expectations drain, bounded
    for (int w = 0; w < 10 && (q0.size() > 0 || q1.size() > 0); w++) @(negedge ck);
    #1;
    chk("drain", q0.size() + q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
